// File: rtl/neuron_mac_accumulator.sv
// Neuron MAC: accumulates INT8 weight x activation products over a row, then adds bias,
// applies a rounding right-shift and saturates to INT8. Optional macro NEURON_RELU_EN clamps negatives to 0.
module neuron_mac_accumulator #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [31:0]       bias_i,
    input  logic [4:0]        shift_i,
    input  logic              w_valid_i,
    input  logic [7:0]        w_data_i,
    input  logic [31:0]       w_index_i,
    input  logic              w_done_i,
    output logic [ADDR_W-1:0] act_addr_o,
    output logic              act_en_o,
    input  logic [7:0]        act_rdata_i,
    output logic              busy_o,
    output logic              result_valid_o,
    output logic [7:0]        result_o,
    output logic [ACC_W-1:0]  acc_out_o,
    output logic [31:0]       mac_count_o
);

    localparam int unsigned S_W = ((ACC_W > 32) ? ACC_W : 32) + 2;
    localparam logic signed [S_W-1:0] SAT_MAX = S_W'(127);
    localparam logic signed [S_W-1:0] SAT_MIN = S_W'(-128);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINAL  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]             mac_q, mac_d;
    logic [7:0]              w_d_q, w_d_d;
    logic                    v_d_q, v_d_d;
    logic                    done_d_q, done_d_d;
    logic signed [31:0]      bias_q, bias_d;
    logic [4:0]              shift_q, shift_d;

    logic                    busy_q, busy_d;
    logic                    result_valid_q, result_valid_d;
    logic [7:0]              result_q, result_d;
    logic [ACC_W-1:0]        acc_out_q, acc_out_d;
    logic [31:0]             mac_out_q, mac_out_d;

    logic signed [15:0]      prod_c;
    logic signed [S_W-1:0]   rnd_c;
    logic signed [S_W-1:0]   sum_c;
    logic signed [S_W-1:0]   shifted_c;
    logic [7:0]              sat_c;
    logic                    in_accum_c;
    logic                    unused_c;

    assign act_addr_o = w_index_i[ADDR_W-1:0];
    assign act_en_o   = w_valid_i && (state_q == ST_ACCUM);
    assign unused_c   = ^w_index_i[31:ADDR_W];

    assign busy_o         = busy_q;
    assign result_valid_o = result_valid_q;
    assign result_o       = result_q;
    assign acc_out_o      = acc_out_q;
    assign mac_count_o    = mac_out_q;

    // Once the registered done is seen the row is closing; later strobes are dropped.
    assign in_accum_c = (state_q == ST_ACCUM) && !done_d_q;
    assign prod_c     = 16'($signed(w_d_q)) * 16'($signed(act_rdata_i));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start restarts the row from any state
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = ST_ACCUM;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ACCUM:  if (done_d_q) state_d = ST_FINAL;
                ST_FINAL:  state_d = ST_OUTPUT;
                ST_OUTPUT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Bias add, round-half-up shift and INT8 saturation; wide enough that nothing wraps
    always_comb begin
        rnd_c = '0;
        if (shift_q != 5'd0) begin
            rnd_c = S_W'(1) << (shift_q - 5'd1);
        end
        sum_c     = S_W'(acc_q) + S_W'(bias_q) + rnd_c;
        shifted_c = sum_c >>> shift_q;
`ifdef NEURON_RELU_EN
        if (shifted_c < 0) begin
            shifted_c = '0;
        end
`else
`endif
        if (shifted_c > SAT_MAX) begin
            sat_c = 8'h7f;
        end else if (shifted_c < SAT_MIN) begin
            sat_c = 8'h80;
        end else begin
            sat_c = shifted_c[7:0];
        end
    end

    // Datapath next-state
    always_comb begin
        acc_d     = acc_q;
        mac_d     = mac_q;
        w_d_d     = w_d_q;
        v_d_d     = 1'b0;
        done_d_d  = 1'b0;
        bias_d    = bias_q;
        shift_d   = shift_q;
        result_d  = result_q;
        acc_out_d = acc_out_q;
        mac_out_d = mac_out_q;

        if (start_i) begin
            acc_d   = '0;
            mac_d   = '0;
            w_d_d   = '0;
            bias_d  = $signed(bias_i);
            shift_d = shift_i;
        end else begin
            if (v_d_q) begin
                acc_d = acc_q + ACC_W'(prod_c);
                mac_d = mac_q + 32'd1;
            end
            if (in_accum_c) begin
                v_d_d    = w_valid_i;
                done_d_d = w_done_i;
                if (w_valid_i) begin
                    w_d_d = w_data_i;
                end
            end
            if (state_q == ST_FINAL) begin
                result_d  = sat_c;
                acc_out_d = acc_q;
                mac_out_d = mac_q;
            end
        end

        busy_d         = (state_d != ST_IDLE);
        result_valid_d = (state_d == ST_OUTPUT);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            mac_q          <= '0;
            w_d_q          <= '0;
            v_d_q          <= 1'b0;
            done_d_q       <= 1'b0;
            bias_q         <= '0;
            shift_q        <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            acc_out_q      <= '0;
            mac_out_q      <= '0;
        end else begin
            acc_q          <= acc_d;
            mac_q          <= mac_d;
            w_d_q          <= w_d_d;
            v_d_q          <= v_d_d;
            done_d_q       <= done_d_d;
            bias_q         <= bias_d;
            shift_q        <= shift_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            acc_out_q      <= acc_out_d;
            mac_out_q      <= mac_out_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Bench for neuron_mac_accumulator: table vectors, hand-written corner sequences and
// randomized rows checked against an arithmetic reference model.
module tb_neuron_mac_accumulator;

`ifdef NEURON_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bias;
    logic [4:0]  shift;
    logic        w_valid;
    logic [7:0]  w_data;
    logic [31:0] w_index;
    logic        w_done;
    logic [9:0]  act_addr;
    logic        act_en;
    logic [7:0]  act_rdata;
    logic        busy;
    logic        result_valid;
    logic [7:0]  result;
    logic [31:0] acc_out;
    logic [31:0] mac_count;

    logic [7:0]  mem [0:1023];
    int          tw [0:15];
    int          ta [0:15];
    int          tests  = 0;
    int          failed = 0;
    int          rv_count = 0;

    typedef struct packed {
        int              n;
        logic [3:0][7:0] w;
        logic [3:0][7:0] a;
        int              bias;
        logic [4:0]      shift;
        int              e_acc;
        int              e_res;
        int              e_mac;
    } vec_t;

    vec_t vecs [0:5];

    neuron_mac_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .bias_i         (bias),
        .shift_i        (shift),
        .w_valid_i      (w_valid),
        .w_data_i       (w_data),
        .w_index_i      (w_index),
        .w_done_i       (w_done),
        .act_addr_o     (act_addr),
        .act_en_o       (act_en),
        .act_rdata_i    (act_rdata),
        .busy_o         (busy),
        .result_valid_o (result_valid),
        .result_o       (result),
        .acc_out_o      (acc_out),
        .mac_count_o    (mac_count)
    );

    always #5 clk = ~clk;

    // Activation buffer: data one cycle after the enable
    always @(posedge clk) begin
        if (act_en) act_rdata <= mem[act_addr];
    end

    always @(negedge clk) begin
        if (result_valid) rv_count <= rv_count + 1;
    end

    task automatic chk(input string name, input longint actual, input longint expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic st, input logic wv, input logic [7:0] wd,
                         input int wi, input logic dn);
        start   = st;
        w_valid = wv;
        w_data  = wd;
        w_index = wi;
        w_done  = dn;
        @(posedge clk); #1;
        start   = 1'b0;
        w_valid = 1'b0;
        w_done  = 1'b0;
    endtask

    // k0 = cycles already elapsed since the w_done cycle
    task automatic wait_result(input int k0, input longint e_acc, input longint e_res,
                               input longint e_mac);
        int k;
        bit seen;
        k = k0;
        seen = 1'b0;
        while (k <= 10 && !seen) begin
            if (result_valid) seen = 1'b1;
            else begin
                drive(1'b0, 1'b0, 8'd0, 0, 1'b0);
                k++;
            end
        end
        chk("rv_latency", seen ? longint'(k) : -1, 3);
        if (seen) begin
            chk("result",    longint'($signed(result)), e_res);
            chk("acc_out",   longint'($signed(acc_out)), e_acc);
            chk("mac_count", longint'(mac_count), e_mac);
            chk("busy_out",  longint'(busy), 1);
            drive(1'b0, 1'b0, 8'd0, 0, 1'b0);
            chk("rv_pulse",  longint'(result_valid), 0);
            chk("busy_idle", longint'(busy), 0);
        end
    endtask

    task automatic run_row(input int n, input int b, input int sh, input bit coincide,
                           input bit gaps, input longint e_acc, input longint e_res,
                           input longint e_mac);
        for (int i = 0; i < n; i++) mem[i] = 8'(ta[i]);
        bias  = b;
        shift = 5'(sh);
        drive(1'b1, 1'b0, 8'd0, 0, 1'b0);
        chk("busy_start", longint'(busy), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 8'd0, 0, 1'b0);
            drive(1'b0, 1'b1, 8'(tw[i]), i, coincide && (i == n - 1));
        end
        if (!(coincide && n > 0)) drive(1'b0, 1'b0, 8'd0, 0, 1'b1);
        wait_result(1, e_acc, e_res, e_mac);
    endtask

    // Reference: exact sum wrapped to 32 bits, then rounding shift and clamp on wide integers
    task automatic model(input int n, input int b, input int sh,
                         output longint e_acc, output longint e_res);
        int     acc;
        longint s;
        longint r;
        acc = 0;
        for (int i = 0; i < n; i++) acc += tw[i] * ta[i];
        e_acc = longint'(acc);
        s = longint'(acc) + longint'(b) + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 0);
        r = s >>> sh;
        if (RELU && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        e_res = r;
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] w, input logic [31:0] a,
                                input int b, input int sh, input int ea, input int er,
                                input int em);
        vec_t v;
        v.n = n; v.w = w; v.a = a; v.bias = b; v.shift = 5'(sh);
        v.e_acc = ea; v.e_res = er; v.e_mac = em;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     rv0;
        longint e_acc;
        longint e_res;
        int     n;
        int     b;
        int     sh;

        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        rst = 1'b1; start = 1'b0; bias = '0; shift = '0;
        w_valid = 1'b0; w_data = '0; w_index = '0; w_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy",   longint'(busy), 0);
        chk("rst_rv",     longint'(result_valid), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_acc",    longint'(acc_out), 0);
        chk("rst_mac",    longint'(mac_count), 0);

        vecs[0] = mk(4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 20, 2, 300, 80, 4);
        vecs[1] = mk(4, {4{8'd127}}, {4{8'd127}}, 0, 4, 64516, 127, 4);
        vecs[2] = mk(3, {8'h00, 8'h80, 8'h80, 8'h80}, {8'd0, 8'd127, 8'd127, 8'd127}, 0, 0,
                     -48768, RELU ? 0 : -128, 3);
        vecs[3] = mk(0, 32'd0, 32'd0, -5, 0, 0, RELU ? 0 : -5, 0);
        vecs[4] = mk(1, 32'h1, 32'h6, 0, 2, 6, 2, 1);
        vecs[5] = mk(1, 32'hff, 32'h6, 0, 2, -6, RELU ? 0 : -1, 1);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                tw[i] = int'($signed(vecs[v].w[i]));
                ta[i] = int'($signed(vecs[v].a[i]));
            end
            run_row(vecs[v].n, vecs[v].bias, int'(vecs[v].shift), (v % 2) == 0, 1'b0,
                    vecs[v].e_acc, vecs[v].e_res, vecs[v].e_mac);
        end

        // Strobes in IDLE are ignored
        rv0 = rv_count;
        w_valid = 1'b1; w_index = 32'd5; w_done = 1'b1;
        #1;
        chk("idle_act_en", longint'(act_en), 0);
        chk("idle_act_addr", longint'(act_addr), 5);
        @(posedge clk); #1;
        w_valid = 1'b0; w_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", longint'(busy), 0);
        chk("idle_no_rv", longint'(rv_count - rv0), 0);

        // Restart mid-row: only the second row reports
        rv0 = rv_count;
        mem[0] = 8'd5; mem[1] = 8'd5;
        bias = '0; shift = '0;
        drive(1'b1, 1'b0, 8'd0, 0, 1'b0);
        drive(1'b0, 1'b1, 8'd9, 0, 1'b0);
        drive(1'b0, 1'b1, 8'd9, 1, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 0, 1'b0);
        drive(1'b0, 1'b1, 8'd2, 0, 1'b0);
        drive(1'b0, 1'b1, 8'd3, 1, 1'b1);
        wait_result(1, 25, 25, 2);
        chk("restart_single_rv", longint'(rv_count - rv0), 1);

        // Reset mid-row
        rv0 = rv_count;
        drive(1'b1, 1'b0, 8'd0, 0, 1'b0);
        drive(1'b0, 1'b1, 8'd3, 0, 1'b0);
        drive(1'b0, 1'b1, 8'd4, 1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 0, 1'b0);
        rst = 1'b0;
        chk("midrst_busy", longint'(busy), 0);
        repeat (5) drive(1'b0, 1'b0, 8'd0, 0, 1'b0);
        chk("midrst_no_rv", longint'(rv_count - rv0), 0);
        tw[0] = 1; ta[0] = 7;
        run_row(1, 0, 0, 1'b1, 1'b0, 7, 7, 1);

        // Weight strobe right after w_done is not accumulated
        mem[0] = 8'd7; mem[1] = 8'd3;
        bias = '0; shift = '0;
        drive(1'b1, 1'b0, 8'd0, 0, 1'b0);
        drive(1'b0, 1'b1, 8'd1, 0, 1'b1);
        drive(1'b0, 1'b1, 8'd5, 1, 1'b0);
        wait_result(2, 7, 7, 1);

        // Randomized rows against the reference model
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                tw[i] = int'($signed(8'($urandom)));
                ta[i] = int'($signed(8'($urandom)));
            end
            b  = ($urandom_range(0, 1) == 1) ? int'($urandom) : $urandom_range(0, 4000) - 2000;
            sh = $urandom_range(0, 31);
            if (r % 4 == 0) sh = $urandom_range(0, 8);
            model(n, b, sh, e_acc, e_res);
            run_row(n, b, sh, $urandom_range(0, 1) == 1, 1'b1, e_acc, e_res, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
